// File: rtl/pkg_teclado.sv
// Shared FSM states, scan-code constants and register bit positions for the keyboard controller.
package pkg_teclado;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    EXT    = 2'd2,
    DECODE = 2'd3
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Status register (addr 0) read layout
  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 5;

  // Control register (addr 0) write layout
  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVR = 2;

endpackage

// File: rtl/fifo_teclado.sv
// ASCII character buffer: power-of-two depth, wrapping pointers, flush has priority over push/pop.
module fifo_teclado #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       head_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  // A pop frees a slot in the same cycle, so push+pop on a full buffer both proceed
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/ctrl_teclado.sv
// PS/2 keyboard controller: filters break/extended sequences, decodes make codes into an ASCII FIFO.
// Optional interrupt output enabled by defining TECLADO_IRQ_EN.
module ctrl_teclado
  import pkg_teclado::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scan_valid_i,
  input  logic [7:0]  scan_code_i,
  output logic [7:0]  deco_dato_o,
  input  logic [31:0] deco_ascii_i,
  input  logic        addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
`ifdef TECLADO_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  state_t           state_next;
  logic             latch_c;
  logic             push_c;
  logic             late_c;
  logic             pop_c;
  logic             flush_c;
  logic             clr_ovr_c;
  logic             ovr_set_c;
  logic             overrun;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [7:0]       head_c;
  logic             unused_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Extended keys are unsupported: E0 only matters if it leads into a break
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (scan_valid_i) begin
          if (scan_code_i == BREAK_CODE)    state_next = BREAK;
          else if (scan_code_i == EXT_CODE) state_next = EXT;
          else                              state_next = DECODE;
        end
      end
      BREAK: begin
        if (scan_valid_i) state_next = IDLE;
      end
      EXT: begin
        if (scan_valid_i) state_next = (scan_code_i == BREAK_CODE) ? BREAK : IDLE;
      end
      DECODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_c = 1'b0;
    push_c  = 1'b0;
    late_c  = 1'b0;
    unique case (state)
      IDLE: latch_c = scan_valid_i && (scan_code_i != BREAK_CODE) && (scan_code_i != EXT_CODE);
      DECODE: begin
        push_c = (deco_ascii_i[7:0] != 8'h00);
        late_c = scan_valid_i;
      end
      default: ;
    endcase
  end

  assign pop_c     = re_i & addr_i;
  assign flush_c   = we_i & ~addr_i & wdata_i[CTRL_FLUSH];
  assign clr_ovr_c = we_i & ~addr_i & wdata_i[CTRL_CLR_OVR];
  // Bytes arriving mid-decode and pushes into a full buffer (with no pop) are lost
  assign ovr_set_c = late_c | (push_c & full & ~pop_c);

  always_ff @(posedge clk_i) begin
    if (rst_i)        deco_dato_o <= 8'h00;
    else if (latch_c) deco_dato_o <= scan_code_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          overrun <= 1'b0;
    else if (ovr_set_c) overrun <= 1'b1;
    else if (clr_ovr_c) overrun <= 1'b0;
  end

  fifo_teclado #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (deco_ascii_i[7:0]),
    .head_c(head_c),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rdata_o = '0;
    if (addr_i) begin
      rdata_o[7:0] = empty ? 8'h00 : head_c;
    end else begin
      rdata_o[ST_NOT_EMPTY]                = ~empty;
      rdata_o[ST_FULL]                     = full;
      rdata_o[ST_OVERRUN]                  = overrun;
      rdata_o[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(count);
    end
  end

`ifdef TECLADO_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= ~empty | overrun;
  end
`else
  // No interrupt output in this build
`endif

  assign unused_c = ^{deco_ascii_i[31:8], wdata_i[31:3], wdata_i[1]};

endmodule

// File: tb/tb_ctrl_teclado.sv
// Self-checking bench for ctrl_teclado: directed vector table, corner-case sequences, random vs model.
module tb_ctrl_teclado;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        scan_valid_i;
  logic [7:0]  scan_code_i;
  logic [7:0]  deco_dato_o;
  logic [31:0] deco_ascii_i;
  logic        addr_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
`ifdef TECLADO_IRQ_EN
  logic        irq_o;
`endif

  always #5 clk = ~clk;

  // Keyboard-layout decoder stand-in; upper bits are garbage the DUT must ignore
  function automatic logic [7:0] dec(input logic [7:0] c);
    case (c)
      8'h1C:   return 8'h41;
      8'h33:   return 8'h48;
      8'h5A:   return 8'h0D;
      8'h29:   return 8'h20;
      8'h16:   return 8'h31;
      default: return 8'h00;
    endcase
  endfunction

  assign deco_ascii_i = {24'hC0FFEE, dec(deco_dato_o)};

  ctrl_teclado #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .scan_valid_i(scan_valid_i),
    .scan_code_i (scan_code_i),
    .deco_dato_o (deco_dato_o),
    .deco_ascii_i(deco_ascii_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .re_i        (re_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o)
`ifdef TECLADO_IRQ_EN
    ,
    .irq_o       (irq_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: character queue plus protocol context
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic       m_pend;
  logic       m_irq;
  int         m_prefix;   // 0 none, 1 after F0, 2 after E0
  logic [7:0] m_dato;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  code;
    logic        addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_dato;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] c, input logic a,
                              input logic w, input logic rd, input logic [31:0] wd,
                              input logic k, input logic [31:0] er, input logic [7:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.code = c; t.addr = a; t.we = w; t.re = rd; t.wdata = wd;
    t.chk = k; t.exp_rdata = er; t.exp_dato = ed;
    return t;
  endfunction

  function automatic logic [31:0] m_rdata(input logic a);
    logic [31:0] r;
    int n;
    r = '0;
    n = m_q.size();
    if (a) begin
      if (n != 0) r[7:0] = m_q[0];
    end else begin
      r = 32'(n != 0) | (32'(n == DEPTH) << 1) | (32'(m_ovr) << 2) | (32'(n) << 4);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] c, input logic a,
                       input logic w, input logic rd, input logic [31:0] wd);
    rst_i = r; scan_valid_i = v; scan_code_i = c; addr_i = a; we_i = w; re_i = rd; wdata_i = wd;
    @(negedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    drive(1'b0, 1'b1, c, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input logic a);
    drive(1'b0, 1'b0, 8'h00, a, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd_pop();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0);
  endtask

  // Advance model by the inputs of this cycle, then cross the clock edge
  task automatic step();
    logic       push_req;
    logic       pop_ok;
    logic       ovr_set;
    logic       irq_n;
    logic       new_pend;
    logic [7:0] a;
    if (rst_i) begin
      m_q.delete();
      m_ovr = 1'b0; m_pend = 1'b0; m_prefix = 0; m_dato = 8'h00; m_irq = 1'b0;
    end else begin
      irq_n    = (m_q.size() != 0) || m_ovr;
      a        = dec(m_dato);
      push_req = m_pend && (a != 8'h00);
      pop_ok   = re_i && addr_i && (m_q.size() != 0);
      ovr_set  = 1'b0;
      new_pend = 1'b0;
      if (pop_ok) void'(m_q.pop_front());
      if (push_req) begin
        if (m_q.size() < DEPTH) m_q.push_back(a);
        else                    ovr_set = 1'b1;
      end
      if (scan_valid_i) begin
        if (m_pend) begin
          ovr_set = 1'b1;
        end else begin
          case (m_prefix)
            0: begin
              if (scan_code_i == 8'hF0)      m_prefix = 1;
              else if (scan_code_i == 8'hE0) m_prefix = 2;
              else begin
                new_pend = 1'b1;
                m_dato   = scan_code_i;
              end
            end
            1:       m_prefix = 0;
            default: m_prefix = (scan_code_i == 8'hF0) ? 1 : 0;
          endcase
        end
      end
      m_pend = new_pend;
      if (we_i && !addr_i && wdata_i[0]) m_q.delete();
      if (ovr_set)                            m_ovr = 1'b1;
      else if (we_i && !addr_i && wdata_i[2]) m_ovr = 1'b0;
      m_irq = irq_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    key(c); step();
    idle(1'b0); step();
  endtask

  logic [7:0]  codes [9];
  logic        r_r, r_v, r_a, r_w, r_rd;
  logic [7:0]  r_c;
  logic [31:0] r_wd;

  initial begin
    codes = '{8'h1C, 8'h33, 8'h5A, 8'h0E, 8'hF0, 8'hE0, 8'h75, 8'h29, 8'h16};
    rst_i = 1'b1; scan_valid_i = 1'b0; scan_code_i = 8'h00; addr_i = 1'b0;
    we_i = 1'b0; re_i = 1'b0; wdata_i = 32'h0;
    m_q.delete();
    m_ovr = 1'b0; m_pend = 1'b0; m_prefix = 0; m_dato = 8'h00; m_irq = 1'b0;

    // rst valid code addr we re wdata | chk rdata dato  (rdata sampled before the edge)
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 32'h0, 0, 32'h00, 8'h00));
    // 1C, F0, 1C -> one 'A'
    vecs.push_back(mk(0, 1, 8'h1C, 0, 0, 0, 32'h0, 1, 32'h00, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 1, 8'hF0, 0, 0, 0, 32'h0, 1, 32'h11, 8'h1C));
    vecs.push_back(mk(0, 1, 8'h1C, 0, 0, 0, 32'h0, 1, 32'h11, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h41, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h00, 8'h1C));
    // E0 75, E0 F0 75 -> nothing
    vecs.push_back(mk(0, 1, 8'hE0, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 1, 8'h75, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 1, 8'hE0, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 1, 8'hF0, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 1, 8'h75, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    // five 33 -> four 'H' and overrun
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h00, 8'h1C));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h33));
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h11, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h11, 8'h33));
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h21, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h21, 8'h33));
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h31, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h31, 8'h33));
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h43, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h43, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 32'h4, 1, 32'h47, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h43, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h48, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h48, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h48, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 32'h0, 1, 32'h48, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h33));
    // flush; writes to addr 1 ignored
    vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0, 1, 32'h00, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 32'hFFFFFFFF, 1, 32'h00, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 32'h1, 1, 32'h11, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 32'h00, 8'h33));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].code, vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wdata);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
        check($sformatf("vec%0d_dato", i), {24'h0, deco_dato_o}, {24'h0, vecs[i].exp_dato});
      end
      step();
    end

    // Unmapped code, then 5A with exact latency
    key(8'h0E); step();
    idle(1'b0); step();
    idle(1'b0); check("unmapped_no_push", rdata_o, 32'h00); step();
    key(8'h5A); step();
    idle(1'b0); check("lat_n1_empty", rdata_o, 32'h00); step();
    idle(1'b0); check("lat_n2_visible", rdata_o, 32'h11); step();
    rd_pop();   check("lat_data", rdata_o, 32'h0D); step();

    // Reset drops a pending break
    key(8'hF0); step();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0); step();
    idle(1'b0); check("rst_status", rdata_o, 32'h00); step();
    key(8'h5A); step();
    idle(1'b0); step();
    rd_pop();   check("rst_clears_break", rdata_o, 32'h0D); step();

    // Push and pop together on a full buffer
    for (int i = 0; i < 4; i++) send(8'h33);
    key(8'h1C); check("full_status", rdata_o, 32'h43); step();
    rd_pop();   check("full_pop", rdata_o, 32'h48); step();
    idle(1'b0); check("full_pushpop_no_ovr", rdata_o, 32'h43); step();
    for (int i = 0; i < 4; i++) begin
      rd_pop(); check($sformatf("full_drain%0d", i), rdata_o, (i < 3) ? 32'h48 : 32'h41); step();
    end

    // Push and pop together on an empty buffer
    key(8'h5A); step();
    rd_pop();   check("empty_pop_zero", rdata_o, 32'h00); step();
    idle(1'b0); check("empty_push_kept", rdata_o, 32'h11); step();
    rd_pop();   check("empty_push_data", rdata_o, 32'h0D); step();

`ifdef TECLADO_IRQ_EN
    key(8'h1C); check("irq_n0", {31'h0, irq_o}, 32'h0); step();
    idle(1'b0); check("irq_n1", {31'h0, irq_o}, 32'h0); step();
    idle(1'b0); check("irq_n2", {31'h0, irq_o}, 32'h0); step();
    idle(1'b0); check("irq_n3", {31'h0, irq_o}, 32'h1); step();
    rd_pop();   step();
    idle(1'b0); check("irq_m1", {31'h0, irq_o}, 32'h1); step();
    idle(1'b0); check("irq_m2", {31'h0, irq_o}, 32'h0); step();
`endif

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r_r  = ($urandom_range(0, 199) == 0);
      r_v  = ($urandom_range(0, 99) < 30);
      r_c  = codes[$urandom_range(0, 8)];
      r_a  = 1'($urandom_range(0, 1));
      r_w  = ($urandom_range(0, 99) < 4);
      r_rd = ($urandom_range(0, 99) < 25);
      r_wd = $urandom;
      drive(r_r, r_v, r_c, r_a, r_w, r_rd, r_wd);
      check("rand_rdata", rdata_o, m_rdata(r_a));
      check("rand_dato", {24'h0, deco_dato_o}, {24'h0, m_dato});
`ifdef TECLADO_IRQ_EN
      check("rand_irq", {31'h0, irq_o}, {31'h0, m_irq});
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_teclado.md
CTRL_TECLADO -- requirements
Module: ctrl_teclado

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, ASCII buffer entries (power of 2, 2..16).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk_i  in  1  system clock.
REQ-004 Port: rst_i  in  1  synchronous active-high reset.
REQ-005 Port: scan_valid_i  in  1  one-cycle pulse, new PS/2 byte on scan_code_i.
REQ-006 Port: scan_code_i  in  8  PS/2 scan-code byte.
REQ-007 Port: deco_dato_o  out  8  scan code presented to the ASCII decoder.
REQ-008 Port: deco_ascii_i  in  32  decoder result; bits [7:0] are ASCII, 0x00 means unmapped.
REQ-009 Port: addr_i  in  1  CPU register select: 0 is status/control, 1 is data.
REQ-010 Port: we_i  in  1  CPU write strobe.
REQ-011 Port: re_i  in  1  CPU read strobe; pops the FIFO when addr_i=1.
REQ-012 Port: wdata_i  in  32  CPU write data.
REQ-013 Port: rdata_o  out  32  CPU read data, combinational from addr_i.
REQ-014 Port: irq_o  out  1  interrupt request; present only with TECLADO_IRQ_EN.

Function
REQ-015 The FSM SHALL have four states: IDLE, BREAK, EXT and DECODE.
REQ-016 IDLE: on scan_valid_i with 0xF0, go to BREAK; with 0xE0, go to EXT; with any other byte, latch it and go to DECODE.
REQ-017 BREAK: the next valid byte SHALL be discarded, then the FSM returns to IDLE.
REQ-018 EXT: a next byte of 0xF0 goes to BREAK; any other next byte is discarded and the FSM returns to IDLE (extended keys are unsupported).
REQ-019 DECODE lasts exactly 1 cycle; deco_dato_o SHALL hold the latched code from IDLE exit until the next latch.
REQ-020 In DECODE the block SHALL sample deco_ascii_i[7:0]; if it is nonzero, push it to the FIFO; if it is 0x00, drop it; then return to IDLE.
REQ-021 Latency: a scan_valid_i in cycle N SHALL make the entry visible (status bit0=1) in cycle N+2.
REQ-022 A scan_valid_i arriving while in DECODE SHALL be dropped and SHALL set overrun.
REQ-023 A push when the FIFO is full SHALL be dropped and SHALL set overrun (sticky).
REQ-024 A simultaneous pop and push when full SHALL perform both and SHALL NOT set overrun.
REQ-025 A simultaneous pop and push when empty: the read returns 0 and the push proceeds.
REQ-026 Status read (addr 0): bit0 not-empty, bit1 full, bit2 overrun, bits[8:4] count, all other bits 0.
REQ-027 Data read (addr 1): {24'b0, head}; re_i SHALL pop when the FIFO is non-empty.
REQ-028 Data read when empty SHALL return 0x00000000 and SHALL NOT change pointers.
REQ-029 Write addr 0: wdata_i[0]=1 flushes the FIFO; wdata_i[2]=1 clears overrun; other bits are ignored.
REQ-030 Writes to addr 1 SHALL be ignored.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-032 rst_i SHALL force IDLE, an empty FIFO, overrun=0, deco_dato_o=0x00 and irq_o=0.
REQ-033 Reset takes priority over all inputs in the same cycle; a pending F0 or E0 state SHALL be forgotten.

Configuration
REQ-034 The macro TECLADO_IRQ_EN SHALL control the interrupt feature.
REQ-035 With TECLADO_IRQ_EN defined: irq_o is registered and equals (not-empty OR overrun) from the previous cycle.
REQ-036 With TECLADO_IRQ_EN undefined: the irq_o port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Package pkg_teclado SHALL hold the FSM state enum, the constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0, and the status bit positions.
REQ-038 FIFO storage and pointers SHALL live in the sub-module fifo_teclado (push, pop, flush, full, empty, count).

Verification
REQ-039 Input 1C, F0, 1C: exactly one entry; data read returns 0x00000041; status bit0 is then 0.
REQ-040 Input E0 75, E0 F0 75: the FIFO stays empty and status is 0x00000000.
REQ-041 Input five make codes 33 with FIFO_DEPTH=4: four entries of 0x48, status=0x00000047; write 0x4 to addr 0 then gives status 0x00000043.
REQ-042 Unmapped code 0E (decoder returns 0): no push; a single 5A then yields 0x0D visible exactly 2 cycles after its pulse.
REQ-043 Input F0, then rst_i for 1 cycle, then 5A: 0x0D is pushed (the break state is cleared).
REQ-044 With TECLADO_IRQ_EN: irq_o rises at N+3 after a pulse at N, and falls the cycle after the last pop.
